// File: rtl/toggle_hit_collector.sv
// toggle_hit_collector
// Records the first hit of each toggle lane in a sticky bitmap, queues every
// new hit once and drains the queue lowest-lane-first as absolute cover
// indices over a valid/ready stream. Also counts the covered lanes and flags
// full coverage.
module toggle_hit_collector #(
  parameter int WIDTH       = 4,
  parameter int COVER_INDEX = 0,
  parameter int IDX_W       = 32
) (
  input  logic                       gbl_clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           valid,
  input  logic                       en,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IDX_W-1:0]           out_index,
  output logic [$clog2(WIDTH+1)-1:0] hit_count,
  output logic                       covered_all,
  output logic                       drained
);

  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int LANE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;

  logic [WIDTH-1:0]    seen;
  logic [WIDTH-1:0]    pending;

  logic [WIDTH-1:0]    new_hits;
  logic [WIDTH-1:0]    cand;
  logic [WIDTH-1:0]    low_mask;
  logic [LANE_W-1:0]   low_lane;
  logic [CNT_W-1:0]    new_count;
  logic                load;
  logic                cand_any;

  // Hit capture, lowest-lane pick and popcount of freshly seen lanes.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    new_hits  = '0;
    low_mask  = '0;
    low_lane  = '0;
    new_count = '0;
    if (en && (state != DONE)) begin
      new_hits = valid & ~seen;
    end
    cand     = pending | new_hits;
    cand_any = |cand;
    load     = ~out_valid | out_ready;
    for (int i = 0; i < WIDTH; i++) begin
      if (cand[i] && (low_mask == '0)) begin
        low_mask[i] = 1'b1;
        low_lane    = LANE_W'(i);
      end
      new_count = new_count + CNT_W'(new_hits[i]);
    end
  end

  // Next-state decode: the FSM mirrors out_valid/pending/seen.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (cand_any) state_next = PRESENT;
      end
      PRESENT: begin
        if (out_ready && !cand_any) begin
          state_next = (&seen) ? DONE : IDLE;
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset and clear both return to IDLE.
  always_ff @(posedge gbl_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) begin
      state <= IDLE;
    end else if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Bitmap, queue, output register and coverage counters.
  always_ff @(posedge gbl_clk) begin
    if (!reset || clear) begin
      seen        <= '0;
      pending     <= '0;
      out_valid   <= 1'b0;
      out_index   <= '0;
      hit_count   <= '0;
      covered_all <= 1'b0;
    end else begin
      seen        <= seen | new_hits;
      hit_count   <= hit_count + new_count;
      covered_all <= &(seen | new_hits);
      if (load) begin
        if (cand_any) begin
          out_valid <= 1'b1;
          out_index <= IDX_W'(COVER_INDEX) + IDX_W'(low_lane);
          pending   <= cand & ~low_mask;
        end else begin
          out_valid <= 1'b0;
        end
      end else begin
        // Presented index holds while the sink stalls; new hits wait in the queue.
        pending <= pending | new_hits;
      end
    end
  end

  assign drained = ~out_valid & (pending == '0);

endmodule

// File: tb/tb_toggle_hit_collector.sv
// Testbench for toggle_hit_collector (WIDTH=4, COVER_INDEX=100, IDX_W=32).
// A lane-level reference model (sets of seen / queued lanes and the lane on
// the output) advances with every clock edge; scenario tasks compare the DUT
// outputs against it and against fixed expectations.
module tb_toggle_hit_collector;

  localparam int WIDTH = 4;
  localparam int BASE  = 100;
  localparam int IDX_W = 32;

  logic             gbl_clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] valid;
  logic             en;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic [2:0]       hit_count;
  logic             covered_all;
  logic             drained;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_seen[WIDTH];
  bit m_queued[WIDTH];
  int m_shown;        // lane on the output, -1 when nothing presented
  int m_count;

  toggle_hit_collector #(
    .WIDTH      (WIDTH),
    .COVER_INDEX(BASE),
    .IDX_W      (IDX_W)
  ) dut (
    .gbl_clk    (gbl_clk),
    .reset      (reset),
    .valid      (valid),
    .en         (en),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .hit_count  (hit_count),
    .covered_all(covered_all),
    .drained    (drained)
  );

  always #5 gbl_clk = ~gbl_clk;

  task automatic model_clear();
    for (int i = 0; i < WIDTH; i++) begin
      m_seen[i]   = 1'b0;
      m_queued[i] = 1'b0;
    end
    m_shown = -1;
    m_count = 0;
  endtask

  function automatic int m_exp_valid();
    return (m_shown >= 0) ? 1 : 0;
  endfunction

  function automatic int m_exp_drained();
    int any_q = 0;
    for (int i = 0; i < WIDTH; i++) if (m_queued[i]) any_q = 1;
    return (m_shown < 0 && any_q == 0) ? 1 : 0;
  endfunction

  // One clock edge: the model consumes the inputs as applied, then outputs
  // are left to settle 1 time unit past the edge before anyone compares.
  task automatic tick();
    @(posedge gbl_clk);
    if (!reset || clear) begin
      model_clear();
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (valid[i] && en && !m_seen[i]) begin
          m_seen[i]   = 1'b1;
          m_queued[i] = 1'b1;
          m_count++;
        end
      end
      if (m_shown < 0 || out_ready) begin
        int pick = -1;
        for (int i = 0; i < WIDTH; i++) begin
          if (pick < 0 && m_queued[i]) pick = i;
        end
        if (pick >= 0) m_queued[pick] = 1'b0;
        m_shown = pick;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    valid     = '0;
    en        = 1'b1;
    clear     = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    n_checks++;
    if (hit_count !== 3'd0) begin n_fail++; $display("FAIL reset_hit_count: got %0d expected 0", hit_count); end
    n_checks++;
    if (drained !== 1'b1) begin n_fail++; $display("FAIL reset_drained: got %0b expected 1", drained); end
    n_checks++;
    if (covered_all !== 1'b0) begin n_fail++; $display("FAIL reset_covered_all: got %0b expected 0", covered_all); end
    n_checks++;
    if (out_index !== 32'd0) begin n_fail++; $display("FAIL reset_out_index: got %0d expected 0", out_index); end
  endtask

  task automatic test_single_hit();
    valid = 4'b0100;
    tick();
    valid = '0;
    n_checks++;
    if (out_valid !== 1'b1 || out_index !== 32'(BASE + 2))
      begin n_fail++; $display("FAIL single_beat: got v=%0b idx=%0d expected v=1 idx=%0d", out_valid, out_index, BASE + 2); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_one_beat: got v=%0b expected 0", out_valid); end
    n_checks++;
    if (hit_count !== 3'd1) begin n_fail++; $display("FAIL single_hit_count: got %0d expected 1", hit_count); end
    valid = 4'b0100;
    tick();
    valid = '0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || hit_count !== 3'd1)
      begin n_fail++; $display("FAIL repeat_dropped: got v=%0b cnt=%0d expected v=0 cnt=1", out_valid, hit_count); end
  endtask

  task automatic test_backpressure();
    valid     = 4'b1011;
    out_ready = 1'b0;
    tick();
    valid = '0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_index !== 32'(BASE))
        begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%0b idx=%0d expected v=1 idx=%0d", k, out_valid, out_index, BASE); end
      if (k < 2) tick();
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_index !== 32'(BASE + 1))
      begin n_fail++; $display("FAIL drain_second: got v=%0b idx=%0d expected v=1 idx=%0d", out_valid, out_index, BASE + 1); end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_index !== 32'(BASE + 3))
      begin n_fail++; $display("FAIL drain_third: got v=%0b idx=%0d expected v=1 idx=%0d", out_valid, out_index, BASE + 3); end
    n_checks++;
    if (hit_count !== 3'd4) begin n_fail++; $display("FAIL drain_hit_count: got %0d expected 4", hit_count); end
  endtask

  task automatic test_done();
    valid = 4'b0100;
    tick();
    valid = '0;
    n_checks++;
    if (out_valid !== 1'b0 || covered_all !== 1'b1 || drained !== 1'b1)
      begin n_fail++; $display("FAIL done_entry: got v=%0b cov=%0b drn=%0b expected 0 1 1", out_valid, covered_all, drained); end
    valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || hit_count !== 3'd4)
        begin n_fail++; $display("FAIL done_no_beats[%0d]: got v=%0b cnt=%0d expected v=0 cnt=4", k, out_valid, hit_count); end
    end
    valid = '0;
  endtask

  task automatic test_clear();
    clear = 1'b1;
    tick();
    clear     = 1'b0;
    valid     = 4'b0011;
    out_ready = 1'b0;
    tick();
    valid = '0;
    n_checks++;
    if (out_valid !== 1'b1 || out_index !== 32'(BASE))
      begin n_fail++; $display("FAIL clear_setup: got v=%0b idx=%0d expected v=1 idx=%0d", out_valid, out_index, BASE); end
    clear = 1'b1;
    valid = 4'b1111;
    tick();
    clear = 1'b0;
    valid = '0;
    n_checks++;
    if (out_valid !== 1'b0 || hit_count !== 3'd0 || covered_all !== 1'b0 || drained !== 1'b1)
      begin n_fail++; $display("FAIL clear_flush: got v=%0b cnt=%0d cov=%0b drn=%0b expected 0 0 0 1", out_valid, hit_count, covered_all, drained); end
    out_ready = 1'b1;
    valid     = 4'b0001;
    tick();
    valid = '0;
    n_checks++;
    if (out_valid !== 1'b1 || out_index !== 32'(BASE) || hit_count !== 3'd1)
      begin n_fail++; $display("FAIL clear_rehit: got v=%0b idx=%0d cnt=%0d expected v=1 idx=%0d cnt=1", out_valid, out_index, hit_count, BASE); end
    tick();
  endtask

  task automatic test_enable();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    en    = 1'b0;
    valid = 4'b1111;
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || hit_count !== 3'd0)
      begin n_fail++; $display("FAIL en_low_ignored: got v=%0b cnt=%0d expected v=0 cnt=0", out_valid, hit_count); end
    en = 1'b1;
    tick();
    en = 1'b0;
    for (int lane = 0; lane < WIDTH; lane++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_index !== 32'(BASE + lane))
        begin n_fail++; $display("FAIL en_drain[%0d]: got v=%0b idx=%0d expected v=1 idx=%0d", lane, out_valid, out_index, BASE + lane); end
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0 || hit_count !== 3'd4 || covered_all !== 1'b1)
      begin n_fail++; $display("FAIL en_drain_end: got v=%0b cnt=%0d cov=%0b expected 0 4 1", out_valid, hit_count, covered_all); end
    en    = 1'b1;
    valid = '0;
  endtask

  task automatic test_reset_mid_present();
    clear = 1'b1;
    tick();
    clear     = 1'b0;
    valid     = 4'b0110;
    out_ready = 1'b0;
    tick();
    valid = '0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || out_index !== 32'd0 || hit_count !== 3'd0 || covered_all !== 1'b0 || drained !== 1'b1)
      begin n_fail++; $display("FAIL reset_mid: got v=%0b idx=%0d cnt=%0d cov=%0b drn=%0b expected 0 0 0 0 1", out_valid, out_index, hit_count, covered_all, drained); end
    out_ready = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      valid     = WIDTH'($urandom_range(0, 15)) & WIDTH'($urandom_range(0, 15));
      en        = ($urandom_range(0, 7) != 0);
      clear     = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      n_checks++;
      if (out_valid !== 1'(m_exp_valid()))
        begin n_fail++; $display("FAIL rnd_out_valid@%0d: got %0b expected %0d", n, out_valid, m_exp_valid()); end
      if (m_shown >= 0) begin
        n_checks++;
        if (out_index !== 32'(BASE + m_shown))
          begin n_fail++; $display("FAIL rnd_out_index@%0d: got %0d expected %0d", n, out_index, BASE + m_shown); end
      end
      n_checks++;
      if (hit_count !== 3'(m_count))
        begin n_fail++; $display("FAIL rnd_hit_count@%0d: got %0d expected %0d", n, hit_count, m_count); end
      n_checks++;
      if (covered_all !== (m_count == WIDTH))
        begin n_fail++; $display("FAIL rnd_covered_all@%0d: got %0b expected %0b", n, covered_all, m_count == WIDTH); end
      n_checks++;
      if (drained !== 1'(m_exp_drained()))
        begin n_fail++; $display("FAIL rnd_drained@%0d: got %0b expected %0d", n, drained, m_exp_drained()); end
    end
    idle_inputs();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_hit();
    test_backpressure();
    test_done();
    test_clear();
    test_enable();
    test_reset_mid_present();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
